// File: rtl/cpu_reg_package.sv
// Shared types for the rv32 bus arbiter.
// Ownership states and read-latency limit.
package cpu_reg_package;

  typedef enum logic [1:0] {
    CPU_OWN,
    HALT_WAIT,
    EXT_OWN,
    DRAIN
  } arb_state_t;

  localparam int ArbReadLatencyMax = 4;

endpackage

// File: rtl/rd_pending_pipe.sv
// Tracks in-flight external reads and returns
// their data one cycle after the bus delivers it.
module rd_pending_pipe #(
  parameter int ReadLatency = 1,
  parameter int data_width  = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  accept,
  input  logic [data_width-1:0] bus_rdata_i,
  output logic                  ext_rvalid_o,
  output logic [data_width-1:0] ext_rdata_o,
  output logic                  empty
);

  logic [ReadLatency-1:0] inflight;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      inflight     <= '0;
      ext_rvalid_o <= 1'b0;
      ext_rdata_o  <= '0;
    end else begin
      inflight[0] <= accept;
      for (int i = 1; i < ReadLatency; i++) begin
        inflight[i] <= inflight[i-1];
      end
      ext_rvalid_o <= inflight[ReadLatency-1];
      if (inflight[ReadLatency-1]) begin
        ext_rdata_o <= bus_rdata_i;
      end
    end
  end

  assign empty = ~|inflight;

endmodule

// File: rtl/bus_arbiter_rv32.sv
// Shares the core bus with one external master by
// halting the core, then granting bounded ownership.
module bus_arbiter_rv32
  import cpu_reg_package::*;
#(
  parameter int address_width    = 32,
  parameter int data_width       = 32,
  parameter int ReadLatency      = 1,
  parameter int HaltSettleCycles = 1,
  parameter int MaxGrantCycles   = 256,
  parameter int CpuMinCycles     = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] cpu_address_i,
  input  logic [data_width-1:0]    cpu_data_i,
  input  logic                     cpu_we_i,
  input  logic [3:0]               cpu_we_ram_i,
  output logic                     cpu_halt_o,
  input  logic                     ext_req_i,
  output logic                     ext_gnt_o,
  input  logic                     ext_valid_i,
  input  logic [address_width-1:0] ext_address_i,
  input  logic [data_width-1:0]    ext_data_i,
  input  logic                     ext_we_i,
  input  logic [3:0]               ext_we_ram_i,
  output logic [data_width-1:0]    ext_rdata_o,
  output logic                     ext_rvalid_o,
  input  logic [data_width-1:0]    bus_rdata_i,
  output logic [address_width-1:0] bus_address_o,
  output logic [data_width-1:0]    bus_data_o,
  output logic                     bus_we_o,
  output logic [3:0]               bus_we_ram_o
);

  localparam int RL =
    (ReadLatency < 1) ? 1 :
    (ReadLatency > ArbReadLatencyMax) ? ArbReadLatencyMax :
    ReadLatency;
  localparam int OW = $clog2(CpuMinCycles + 2);
  localparam int GW =
    (MaxGrantCycles > 1) ? $clog2(MaxGrantCycles) : 1;

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [OW-1:0] own_cnt;
  logic [GW-1:0] grant_cnt;
  logic [3:0]    halt_cnt;
  logic          own_done;
  logic          settle_done;
  logic          grant_done;
  logic          accept;
  logic          empty;

  // own_cnt excludes the current cycle, hence the -1
  assign own_done =
    (CpuMinCycles == 0) ||
    (own_cnt >= OW'(CpuMinCycles - 1));
  assign settle_done =
    (halt_cnt == 4'(HaltSettleCycles - 1));
  assign grant_done =
    (MaxGrantCycles != 0) &&
    (grant_cnt == GW'(MaxGrantCycles - 1));
  assign accept = ext_gnt_o & ext_valid_i & ~ext_we_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= CPU_OWN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      own_cnt   <= '0;
      grant_cnt <= '0;
      halt_cnt  <= '0;
    end else begin
      if (state == DRAIN && state_nxt == CPU_OWN) begin
        own_cnt <= '0;
      end else if (state == CPU_OWN &&
                   own_cnt != OW'(CpuMinCycles)) begin
        own_cnt <= own_cnt + 1'b1;
      end
      halt_cnt  <= (state == HALT_WAIT) ?
                   halt_cnt + 1'b1 : '0;
      grant_cnt <= (state == EXT_OWN) ?
                   grant_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CPU_OWN: begin
        if (ext_req_i && own_done) state_nxt = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (!ext_req_i)       state_nxt = CPU_OWN;
        else if (settle_done) state_nxt = EXT_OWN;
      end
      EXT_OWN: begin
        if (!ext_req_i || grant_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty) state_nxt = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  always_comb begin
    cpu_halt_o    = (state != CPU_OWN);
    ext_gnt_o     = (state == EXT_OWN);
    bus_address_o = cpu_address_i;
    bus_data_o    = cpu_data_i;
    bus_we_o      = 1'b0;
    bus_we_ram_o  = 4'h0;
    unique case (state)
      CPU_OWN: begin
        bus_we_o     = cpu_we_i;
        bus_we_ram_o = cpu_we_ram_i;
      end
      EXT_OWN: begin
        bus_address_o = ext_address_i;
        bus_data_o    = ext_data_i;
        bus_we_o      = ext_valid_i & ext_we_i;
        bus_we_ram_o  = ext_valid_i ? ext_we_ram_i : 4'h0;
      end
      default: begin
        bus_we_o     = 1'b0;
        bus_we_ram_o = 4'h0;
      end
    endcase
  end

  rd_pending_pipe #(
    .ReadLatency (RL),
    .data_width  (data_width)
  ) u_rd_pipe (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .accept       (accept),
    .bus_rdata_i  (bus_rdata_i),
    .ext_rvalid_o (ext_rvalid_o),
    .ext_rdata_o  (ext_rdata_o),
    .empty        (empty)
  );

endmodule
